// File: rtl/id_hazard_fwd_if.sv
// Bundle between the ID stage and the hazard/forwarding unit: ID instruction
// fields, the candidate bypass values and the resulting operands and stall.
interface id_hazard_fwd_if #(
  parameter int STALL_CNT_W = 32
);
  logic                   id_valid;
  logic [4:0]             id_rs1;
  logic [4:0]             id_rs2;
  logic                   id_use1;
  logic                   id_use2;
  logic [4:0]             id_rd;
  logic                   id_we;
  logic                   id_is_load;
  logic                   flush;
  logic [31:0]            rf_rD1;
  logic [31:0]            rf_rD2;
  logic [31:0]            ex_result;
  logic [31:0]            mem_result;
  logic [31:0]            mem_load_data;
  logic [31:0]            wb_value;
  logic [31:0]            fwd_rD1;
  logic [31:0]            fwd_rD2;
  logic                   stall_id;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_we, id_is_load,
           flush, rf_rD1, rf_rD2, ex_result, mem_result, mem_load_data, wb_value,
    input  fwd_rD1, fwd_rD2, stall_id, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_we, id_is_load,
           flush, rf_rD1, rf_rD2, ex_result, mem_result, mem_load_data, wb_value,
    output fwd_rD1, fwd_rD2, stall_id, stall_cnt
  );
endinterface

// File: rtl/id_hazard_fwd.sv
// ID-stage hazard detection and operand bypass. Only destination tags of the
// EX/MEM/WB instructions are stored; every data value passes through
// combinationally. FWD_EN=0 turns the unit into a pure interlock.
module id_hazard_fwd #(
  parameter bit FWD_EN      = 1'b1,
  parameter int STALL_CNT_W = 32
) (
  input  logic           rf_clk,
  input  logic           rf_rst,
  id_hazard_fwd_if.slave bus
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       is_load;
  } tag_t;

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  tag_t                   ex_q, ex_d, mem_q, wb_q;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic                   s1_ex, s1_mem, s1_wb;
  logic                   s2_ex, s2_mem, s2_wb;
  logic                   stall_raw, stall;
  logic [31:0]            mem_v;
  logic [31:0]            fwd1, fwd2;

  // r0 is hard-wired zero, so a write to it never creates a dependency.
  function automatic logic src_hit(input tag_t t, input logic [4:0] src, input logic used);
    return t.valid & t.we & (t.rd == src) & (src != 5'd0) & used;
  endfunction

  // Youngest producer wins. A load in EX has no data yet: keep the RF value
  // rather than falling through to an older MEM/WB result (the stall covers it).
  function automatic logic [31:0] bypass(input logic h_ex, input logic h_mem, input logic h_wb,
                                         input logic ex_ld, input logic [31:0] rf,
                                         input logic [31:0] ex_v, input logic [31:0] mem_v_i,
                                         input logic [31:0] wb_v);
    if (!FWD_EN) return rf;
    if (h_ex)    return ex_ld ? rf : ex_v;
    if (h_mem)   return mem_v_i;
    if (h_wb)    return wb_v;
    return rf;
  endfunction

  // Match each used source against each in-flight destination tag.
  always_comb begin
    s1_ex  = src_hit(ex_q,  bus.id_rs1, bus.id_use1);
    s1_mem = src_hit(mem_q, bus.id_rs1, bus.id_use1);
    s1_wb  = src_hit(wb_q,  bus.id_rs1, bus.id_use1);
    s2_ex  = src_hit(ex_q,  bus.id_rs2, bus.id_use2);
    s2_mem = src_hit(mem_q, bus.id_rs2, bus.id_use2);
    s2_wb  = src_hit(wb_q,  bus.id_rs2, bus.id_use2);
  end

  // Load-use interlock with bypass, any-hit interlock without; flush overrides.
  always_comb begin
    if (FWD_EN) stall_raw = (s1_ex | s2_ex) & ex_q.is_load;
    else        stall_raw = s1_ex | s1_mem | s1_wb | s2_ex | s2_mem | s2_wb;
    stall = stall_raw & ~bus.flush;
  end

  // Operand selection onto the ID/EX register inputs.
  always_comb begin
    mem_v = mem_q.is_load ? bus.mem_load_data : bus.mem_result;
    fwd1  = bypass(s1_ex, s1_mem, s1_wb, ex_q.is_load, bus.rf_rD1, bus.ex_result, mem_v, bus.wb_value);
    fwd2  = bypass(s2_ex, s2_mem, s2_wb, ex_q.is_load, bus.rf_rD2, bus.ex_result, mem_v, bus.wb_value);
  end

  // Next EX tag (bubble when stalled, flushed or empty) and saturating stall count.
  always_comb begin
    ex_d = '0;
    if (!(stall | bus.flush | ~bus.id_valid))
      ex_d = '{valid: 1'b1, rd: bus.id_rd, we: bus.id_we, is_load: bus.id_is_load};
    cnt_d = cnt_q;
    if (stall && (cnt_q != {STALL_CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_ONE;
  end

  // Tag pipeline and counter; reset clears tags at once so the stall drops immediately.
  always_ff @(posedge rf_clk or posedge rf_rst) begin
    if (rf_rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      cnt_q <= cnt_d;
    end
  end

  assign bus.fwd_rD1   = fwd1;
  assign bus.fwd_rD2   = fwd2;
  assign bus.stall_id  = stall;
  assign bus.stall_cnt = cnt_q;

endmodule
